bcd_timekeeper: RTL and testbench
=================================

# bcd_timekeeper

Avalon-MM slave that keeps time of day as packed BCD HH:MM:SS, advancing once per second from a prescaled system clock. It sits directly upstream of the six-digit seven-segment display register. Its `time_bcd` bus and `upd` strobe feed that register's write path, so the display follows the clock without CPU involvement. The CPU can read, set, stop and start the time over the bus.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency, which sets the prescaler terminal count (CLK_HZ-1). Minimum 2.
- `clk` in 1: system clock; everything is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 2: register select (0 TIME, 1 CTRL, 2 STATUS, 3 ALARM).
- `read` in 1: read strobe.
- `write` in 1: write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: read data. Combinational; 0 when `read` is low.
- `time_bcd` out 24: {H1,H0,M1,M0,S1,S0}, one nibble per digit, registered.
- `upd` out 1: one-cycle pulse whenever `time_bcd` changes.
- `alarm_irq` out 1: alarm interrupt, level-sensitive.

## Operation
**Reset values**
- `time_bcd` = 24'h000000; `upd` = 0; `alarm_irq` = 0.
- Prescaler = 0; CTRL = 3'b001 (run=1, alarm_en=0); STATUS = 0; ALARM = 24'h000000.

**Registers**
- TIME
  - Read: {8'h00, time_bcd}.
  - Write: loads writedata[23:0] only if every field is legal BCD: S1, M1 ≤ 5; S0, M0 ≤ 9; hours 00–23.
  - A legal write clears the prescaler to 0.
  - An illegal write leaves time unchanged and sets STATUS.err.
- CTRL (bits 2:0)
  - bit0 `run`: 0 freezes both the prescaler and the counters.
  - bit2 `alarm_en`.
- STATUS
  - bit0 `tick`: sticky; set on every second increment.
  - bit1 `err`.
  - bit2 `alarm`.
  - Clearing: writing 1 to a bit clears it (W1C). If set and clear hit the same cycle, set wins.

**Counting**
- Prescaler counts 0 to CLK_HZ-1 while `run`=1.
- At terminal count, on the same edge: prescaler returns to 0 and seconds increment.
- Carry chain within that single edge:
  - S 59 → 00 carries into minutes.
  - M 59 → 00 carries into hours.
  - H 23 → 00 wraps with no further carry.
- Each BCD digit pair rolls as a decimal: 09 → 10, never 0A.

**Simultaneous events**
- TIME write on the terminal-count cycle: the write wins and the increment is discarded.
- CTRL write clearing `run` on the terminal-count cycle: the increment still occurs this cycle; counting stops from the next edge.

**Alarm**
- When `alarm_en`=1 and the newly registered `time_bcd` equals ALARM, STATUS.alarm is set.
- `alarm_irq` = STATUS.alarm & `alarm_en`.
- A match caused by a TIME write also fires.

**Reset mid-operation:** all state returns to the reset values immediately, regardless of clock.

## Timing
- `time_bcd` and `upd` are registered and change on the same edge as the increment or legal TIME write. `upd` is high for exactly that cycle.
- A read of TIME in the cycle after an update returns the new value.
- No wait states; `read` and `write` are never asserted together.
- Alarm flag and `alarm_irq` assert one cycle after the matching `time_bcd` edge.

## Configuration
- `BCD_TIMEKEEPER_ALARM_EN` defined: the ALARM register, CTRL.alarm_en, STATUS.alarm and `alarm_irq` are implemented as described.
- Macro not defined:
  - Address 3 reads 0 and ignores writes.
  - CTRL bit2 reads 0; STATUS bit2 reads 0.
  - `alarm_irq` is tied to 0; the port remains present.

## Structure
- Package `bcd_timekeeper_pkg` holds:
  - Register address constants: ADDR_TIME, ADDR_CTRL, ADDR_STATUS, ADDR_ALARM.
  - CTRL and STATUS bit indices.
  - Reset constants for CTRL and time.
  - BCD limit constants: 59 and 23.
- Sub-module `bcd_mod_counter`: two-digit BCD counter.
  - Parameter MAX (59 or 23).
  - Inputs: inc, load, load_val. Output: carry.
  - Instantiated three times (seconds, minutes, hours).
- Prescaler, register file and alarm compare stay in the top module.

## Test plan
All scenarios run with `CLK_HZ`=4.
1. Reset, then run 4 cycles → time_bcd=24'h000001, one `upd` pulse, STATUS=1.
2. Write TIME=24'h235959, wait 4 cycles → time_bcd=24'h000000, with a single `upd` pulse on the wrap edge.
3. Write TIME=24'h12AB00 → time unchanged, STATUS.err=1. Then write STATUS=2 → err cleared.
4. Write TIME=24'h000009 on the terminal-count cycle → time_bcd=24'h000009, not 24'h000010. The next increment comes 4 cycles later → 24'h000010.
5. Write CTRL=0, wait 20 cycles → time frozen, no `upd`. Write CTRL=1 → counting resumes 4 cycles later.
6. Alarm build only: ALARM=24'h000002, CTRL=5, run 8 cycles from 24'h000000 → `alarm_irq` rises one cycle after time_bcd=24'h000002. Write STATUS=4 → `alarm_irq` falls.

Source files
------------

// File: rtl/bcd_timekeeper_pkg.sv
// Shared register map, bit positions, reset values and BCD limits for bcd_timekeeper.
package bcd_timekeeper_pkg;

    localparam logic [1:0] ADDR_TIME   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_ALARM  = 2'd3;

    localparam int CTRL_RUN_BIT      = 0;
    localparam int CTRL_ALARM_EN_BIT = 2;

    localparam int STATUS_TICK_BIT  = 0;
    localparam int STATUS_ERR_BIT   = 1;
    localparam int STATUS_ALARM_BIT = 2;

    localparam logic [2:0]  CTRL_RESET = 3'b001;
    localparam logic [23:0] TIME_RESET = 24'h000000;

    localparam logic [7:0] BCD_MAX_SEC_MIN = 8'h59;
    localparam logic [7:0] BCD_MAX_HOUR    = 8'h23;

    // Every digit must be decimal; tens limits then bound each field to its range.
    function automatic logic isLegalTime(logic [23:0] t);
        logic digitsOk;
        digitsOk = (t[3:0] <= 4'd9) && (t[11:8] <= 4'd9) && (t[19:16] <= 4'd9);
        return digitsOk && (t[7:4] <= 4'd5) && (t[15:12] <= 4'd5) && (t[23:16] <= BCD_MAX_HOUR);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps after MAX and flags the wrap as a carry.
module bcd_mod_counter
    import bcd_timekeeper_pkg::*;
#(
    parameter logic [7:0] MAX = BCD_MAX_SEC_MIN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic [7:0] value_o,
    output logic       carry_o
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    // A load always overrides a pending increment.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (inc_i) begin
            if (value_q == MAX) begin
                value_d = 8'h00;
            end else if (value_q[3:0] == 4'd9) begin
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 8'h00;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign carry_o = inc_i && !load_i && (value_q == MAX);

endmodule

// File: rtl/bcd_timekeeper.sv
// Avalon-MM BCD time-of-day keeper feeding the seven-segment display register.
// Define BCD_TIMEKEEPER_ALARM_EN to build the ALARM register, alarm_en, STATUS.alarm and alarm_irq.
module bcd_timekeeper
    import bcd_timekeeper_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [23:0] time_bcd,
    output logic        upd,
    output logic        alarm_irq
);

    localparam int             PW       = $clog2(CLK_HZ);
    localparam logic [PW-1:0]  PRESC_TC = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          run_q, run_d;
    logic          statusTick_q, statusTick_d;
    logic          statusErr_q, statusErr_d;
    logic          upd_q;

    logic timeWrite, ctrlWrite, statusWrite, timeLegal, timeLoad;
    logic termCount, secInc, secCarry, minCarry, hourCarry;
    logic [7:0] secVal, minVal, hourVal;
    logic alarmEn, statusAlarm;
    logic [23:0] alarmTime;
    logic unused_wdata;

    assign timeWrite   = write && (address == ADDR_TIME);
    assign ctrlWrite   = write && (address == ADDR_CTRL);
    assign statusWrite = write && (address == ADDR_STATUS);
    assign timeLegal   = isLegalTime(writedata[23:0]);
    assign timeLoad    = timeWrite && timeLegal;
    assign termCount   = run_q && (presc_q == PRESC_TC);
    // A TIME write on the terminal-count edge discards that second.
    assign secInc      = termCount && !timeLoad;

    bcd_mod_counter #(.MAX(BCD_MAX_SEC_MIN)) u_sec (
        .clk(clk), .rst_n(reset_n), .inc_i(secInc), .load_i(timeLoad),
        .load_val_i(writedata[7:0]), .value_o(secVal), .carry_o(secCarry)
    );

    bcd_mod_counter #(.MAX(BCD_MAX_SEC_MIN)) u_min (
        .clk(clk), .rst_n(reset_n), .inc_i(secCarry), .load_i(timeLoad),
        .load_val_i(writedata[15:8]), .value_o(minVal), .carry_o(minCarry)
    );

    bcd_mod_counter #(.MAX(BCD_MAX_HOUR)) u_hour (
        .clk(clk), .rst_n(reset_n), .inc_i(minCarry), .load_i(timeLoad),
        .load_val_i(writedata[23:16]), .value_o(hourVal), .carry_o(hourCarry)
    );

    assign time_bcd = {hourVal, minVal, secVal};
    assign upd      = upd_q;

    always_comb begin
        presc_d = presc_q;
        if (timeLoad) begin
            presc_d = '0;
        end else if (run_q) begin
            presc_d = termCount ? '0 : presc_q + PW'(1);
        end
        run_d = ctrlWrite ? writedata[CTRL_RUN_BIT] : run_q;
        // Sticky flags: a set in the same cycle as a W1C clear wins.
        statusTick_d = secInc
                     | (statusTick_q & ~(statusWrite & writedata[STATUS_TICK_BIT]));
        statusErr_d  = (timeWrite & ~timeLegal)
                     | (statusErr_q & ~(statusWrite & writedata[STATUS_ERR_BIT]));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q      <= '0;
            run_q        <= CTRL_RESET[CTRL_RUN_BIT];
            statusTick_q <= 1'b0;
            statusErr_q  <= 1'b0;
            upd_q        <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            run_q        <= run_d;
            statusTick_q <= statusTick_d;
            statusErr_q  <= statusErr_d;
            upd_q        <= timeLoad | secInc;
        end
    end

`ifdef BCD_TIMEKEEPER_ALARM_EN
    logic        alarmEn_q, alarmEn_d;
    logic        statusAlarm_q, statusAlarm_d;
    logic [23:0] alarmTime_q, alarmTime_d;

    // upd_q marks the cycle right after time_bcd took a new value, so a frozen match fires once.
    always_comb begin
        alarmEn_d     = ctrlWrite ? writedata[CTRL_ALARM_EN_BIT] : alarmEn_q;
        alarmTime_d   = (write && (address == ADDR_ALARM)) ? writedata[23:0] : alarmTime_q;
        statusAlarm_d = (upd_q & alarmEn_q & (time_bcd == alarmTime_q))
                      | (statusAlarm_q & ~(statusWrite & writedata[STATUS_ALARM_BIT]));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarmEn_q     <= CTRL_RESET[CTRL_ALARM_EN_BIT];
            alarmTime_q   <= TIME_RESET;
            statusAlarm_q <= 1'b0;
        end else begin
            alarmEn_q     <= alarmEn_d;
            alarmTime_q   <= alarmTime_d;
            statusAlarm_q <= statusAlarm_d;
        end
    end

    assign alarmEn     = alarmEn_q;
    assign statusAlarm = statusAlarm_q;
    assign alarmTime   = alarmTime_q;
    assign alarm_irq   = statusAlarm_q & alarmEn_q;
`else
    assign alarmEn     = 1'b0;
    assign statusAlarm = 1'b0;
    assign alarmTime   = 24'h000000;
    assign alarm_irq   = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        if (read) begin
            case (address)
                ADDR_TIME:   readdata = {8'h00, time_bcd};
                ADDR_CTRL:   readdata = {29'd0, alarmEn, 1'b0, run_q};
                ADDR_STATUS: readdata = {29'd0, statusAlarm, statusErr_q, statusTick_q};
                ADDR_ALARM:  readdata = {8'h00, alarmTime};
                default:     readdata = '0;
            endcase
        end
    end

    assign unused_wdata = &{writedata[31:24], hourCarry};

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Self-checking bench for bcd_timekeeper: directed plan steps plus random bus traffic
// compared cycle by cycle against a seconds-of-day reference model.
module tb_bcd_timekeeper;

    localparam int CLK_HZ = 4;
    localparam int DAY    = 86400;
`ifdef BCD_TIMEKEEPER_ALARM_EN
    localparam bit ALARM_BUILD = 1'b1;
`else
    localparam bit ALARM_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [23:0] time_bcd;
    logic        upd;
    logic        alarm_irq;

    int checks   = 0;
    int failures = 0;
    int updSeen  = 0;

    int          mSecs;
    int          mPresc;
    bit          mRun, mAlarmEn, mTick, mErr, mAlarmFlag, mUpd;
    logic [23:0] mAlarm;

    always #5 clk = ~clk;

    bcd_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .time_bcd(time_bcd),
        .upd(upd), .alarm_irq(alarm_irq)
    );

    function automatic logic [23:0] toBcd(int secs);
        int h, m, s;
        h = secs / 3600;
        m = (secs / 60) % 60;
        s = secs % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Returns seconds of day, or -1 when the value is not a legal time.
    function automatic int fromBcd(logic [23:0] t);
        int d[6];
        int h, m, s;
        for (int i = 0; i < 6; i++) begin
            d[i] = int'(t[4*i +: 4]);
            if (d[i] > 9) return -1;
        end
        s = d[1] * 10 + d[0];
        m = d[3] * 10 + d[2];
        h = d[5] * 10 + d[4];
        if (s > 59 || m > 59 || h > 23) return -1;
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [31:0] expRead(logic [1:0] a);
        case (a)
            2'd0:    return {8'h00, toBcd(mSecs)};
            2'd1:    return {29'd0, mAlarmEn, 1'b0, mRun};
            2'd2:    return {29'd0, mAlarmFlag, mErr, mTick};
            default: return ALARM_BUILD ? {8'h00, mAlarm} : 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        mSecs = 0; mPresc = 0; mRun = 1'b1; mAlarmEn = 1'b0;
        mTick = 1'b0; mErr = 1'b0; mAlarmFlag = 1'b0; mUpd = 1'b0; mAlarm = 24'h0;
    endtask

    task automatic modelEdge(bit wr, logic [1:0] a, logic [31:0] wd);
        bit tc, incr, alarmSet, clr;
        int t;
        tc       = mRun && (mPresc == CLK_HZ - 1);
        alarmSet = ALARM_BUILD && mUpd && mAlarmEn && (toBcd(mSecs) == mAlarm);
        t        = fromBcd(wd[23:0]);
        incr     = 1'b0;
        clr      = wr && (a == 2'd2);
        if (wr && a == 2'd0 && t >= 0) begin
            mSecs = t; mPresc = 0; mUpd = 1'b1;
        end else begin
            if (tc) begin
                mSecs = (mSecs + 1) % DAY;
                incr  = 1'b1;
            end
            mUpd = tc;
            if (mRun) mPresc = tc ? 0 : mPresc + 1;
        end
        mTick      = incr | (mTick & !(clr && wd[0]));
        mErr       = (wr && a == 2'd0 && t < 0) | (mErr & !(clr && wd[1]));
        mAlarmFlag = alarmSet | (mAlarmFlag & !(clr && wd[2]));
        if (wr && a == 2'd1) begin
            mRun = wd[0];
            if (ALARM_BUILD) mAlarmEn = wd[2];
        end
        if (ALARM_BUILD && wr && a == 2'd3) mAlarm = wd[23:0];
    endtask

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One bus cycle: starts and ends at a falling edge.
    task automatic applyStimulus(bit rd, bit wr, logic [1:0] a, logic [31:0] wd, string tag);
        read = rd; write = wr; address = a; writedata = wd;
        #1;
        checkOutput({tag, "/readdata"}, readdata, rd ? expRead(a) : 32'h0);
        @(posedge clk);
        modelEdge(wr, a, wd);
        #1;
        if (upd === 1'b1) updSeen++;
        checkOutput({tag, "/time_bcd"}, 32'(time_bcd), 32'(toBcd(mSecs)));
        checkOutput({tag, "/upd"}, 32'(upd), 32'(mUpd));
        checkOutput({tag, "/alarm_irq"}, 32'(alarm_irq), 32'(mAlarmFlag & mAlarmEn));
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, "idle");
    endtask

    task automatic midReset();
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("reset/time_bcd", 32'(time_bcd), 32'h0);
        checkOutput("reset/upd", 32'(upd), 32'h0);
        checkOutput("reset/alarm_irq", 32'(alarm_irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int op;
        reset_n = 1'b0; read = 1'b0; write = 1'b0; address = 2'd0; writedata = 32'h0;
        modelReset();
        #1;
        checkOutput("por/time_bcd", 32'(time_bcd), 32'h0);
        checkOutput("por/upd", 32'(upd), 32'h0);
        checkOutput("por/alarm_irq", 32'(alarm_irq), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] plan 1: first second after reset");
        updSeen = 0;
        idle(4);
        checkOutput("p1/time", 32'(time_bcd), 32'h000001);
        checkOutput("p1/upd_count", 32'(updSeen), 32'd1);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h0, "p1/status");
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h0, "p1/ctrl");

        $display("[TB] plan 2: midnight wrap");
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h00235959, "p2/wr");
        updSeen = 0;
        idle(4);
        checkOutput("p2/time", 32'(time_bcd), 32'h000000);
        checkOutput("p2/upd_count", 32'(updSeen), 32'd1);

        $display("[TB] plan 3: illegal TIME write");
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h0012AB00, "p3/wr");
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h0, "p3/status");
        checkOutput("p3/err_model", 32'(mErr), 32'd1);
        applyStimulus(1'b0, 1'b1, 2'd2, 32'h2, "p3/clr");
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h0, "p3/status2");

        $display("[TB] plan 4: TIME write on terminal count");
        for (int i = 0; i < 2 * CLK_HZ && mPresc != CLK_HZ - 1; i++) idle(1);
        checkOutput("p4/tc_reached", 32'(mPresc), 32'(CLK_HZ - 1));
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h00000009, "p4/wr");
        checkOutput("p4/time", 32'(time_bcd), 32'h000009);
        idle(3);
        checkOutput("p4/held", 32'(time_bcd), 32'h000009);
        idle(1);
        checkOutput("p4/next", 32'(time_bcd), 32'h000010);

        $display("[TB] plan 5: stop and start");
        applyStimulus(1'b0, 1'b1, 2'd1, 32'h0, "p5/stop");
        updSeen = 0;
        idle(20);
        checkOutput("p5/frozen_upd", 32'(updSeen), 32'd0);
        checkOutput("p5/frozen_time", 32'(time_bcd), 32'h000010);
        applyStimulus(1'b0, 1'b1, 2'd1, 32'h1, "p5/start");
        idle(4);
        checkOutput("p5/resume_upd", 32'(updSeen), 32'd1);
        checkOutput("p5/resume_time", 32'(time_bcd), 32'h000011);

`ifdef BCD_TIMEKEEPER_ALARM_EN
        $display("[TB] plan 6: alarm");
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, "p6/time");
        applyStimulus(1'b0, 1'b1, 2'd3, 32'h000002, "p6/alarm");
        applyStimulus(1'b0, 1'b1, 2'd1, 32'h5, "p6/ctrl");
        idle(8);
        checkOutput("p6/irq_high", 32'(alarm_irq), 32'd1);
        applyStimulus(1'b0, 1'b1, 2'd2, 32'h4, "p6/clr");
        checkOutput("p6/irq_low", 32'(alarm_irq), 32'd0);
`endif

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            if (n == 300) midReset();
            op = int'($urandom_range(0, 15));
            case (op)
                0: applyStimulus(1'b0, 1'b1, 2'd0,
                       32'(toBcd(($urandom_range(0, 1) == 0) ? int'($urandom_range(0, DAY - 1))
                                                             : DAY - int'($urandom_range(1, 3)))),
                       "rnd/time_ok");
                1: applyStimulus(1'b0, 1'b1, 2'd0, {8'h0, 24'($urandom)}, "rnd/time_any");
                2: applyStimulus(1'b0, 1'b1, 2'd1,
                       {29'd0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 3) != 0)},
                       "rnd/ctrl");
                3: applyStimulus(1'b0, 1'b1, 2'd2, {29'd0, 3'($urandom)}, "rnd/status");
                4: applyStimulus(1'b0, 1'b1, 2'd3,
                       32'(toBcd((mSecs + int'($urandom_range(1, 3))) % DAY)), "rnd/alarm");
                5, 6, 7, 8: applyStimulus(1'b1, 1'b0, 2'($urandom), 32'h0, "rnd/read");
                default: idle(1);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
